// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Oversampling UART receiver with configurable character format and a small
//   first-word-fall-through receive FIFO read through a valid/ready handshake.
//   Each FIFO entry carries the character plus its parity and framing status.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   i_clk_rx      one-clk tick at OVERSAMPLE x baud
//   i_rxd         serial line (idle high), asynchronous to clk
//   i_rx_ready    consumer takes the head entry when high with o_rx_valid
//   o_rx_valid    FIFO holds at least one entry
//   o_rx_data     head character, LSB = first received bit
//   o_parity_err  head entry parity mismatch
//   o_frame_err   head entry had a stop bit sampled low
//   o_overrun     one-clk pulse when a completed character is dropped
//   o_fifo_count  number of entries held
//   o_busy        receiver is inside a frame
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a falling edge on an armed (previously high) line
// S_START  | start bit; a high vote at mid-bit is a false start
// S_DATA   | shifting in DATA_BITS voted bits, LSB first
// S_PARITY | checking the parity bit against the received data
// S_STOP   | stop bit(s); the last one's mid-bit vote pushes the character

module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_clk_rx,
  input  logic                          i_rxd,
  input  logic                          i_rx_ready,
  output logic                          o_rx_valid,
  output logic [DATA_BITS-1:0]          o_rx_data,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy
);

  localparam int M     = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(M);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [AW:0]      CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser (resets to the idle line level)
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   stop_q;     // second stop bit in progress
  logic [DATA_BITS-1:0]   shift_q;
  logic [1:0]             smp_q;      // samples at cnt = M-1 and M
  logic                   arm_q;
  logic                   perr_q;
  logic                   ferr_q;

  logic vote;
  logic dec_tick;
  logic wrap_tick;
  logic last_stop;
  logic push;
  logic [EW-1:0] push_entry;

  // Majority of the two stored samples and the live sample at cnt = M+1
  assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign dec_tick  = i_clk_rx && (cnt_q == CNT_DEC);
  assign wrap_tick = i_clk_rx && (cnt_q == CNT_LAST);
  assign last_stop = (STOP_BITS == 1) || stop_q;

  // The character is handed to the FIFO at the last stop bit's decision point,
  // so the live vote is folded into the framing flag here.
  assign push       = (state_q == S_STOP) && dec_tick && last_stop;
  assign push_entry = {perr_q, ferr_q | ~vote, shift_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      smp_q   <= '0;
      arm_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (i_clk_rx && (state_q != S_IDLE)) begin
        if (cnt_q == CNT_PRE) smp_q[0] <= rxs;
        if (cnt_q == CNT_MID) smp_q[1] <= rxs;
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (arm_q && !rxs) begin
            state_q <= S_START;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end else if (rxs) begin
            arm_q <= 1'b1;
          end
        end

        S_START: begin
          if (dec_tick && vote) begin
            state_q <= S_IDLE;
          end else if (wrap_tick) begin
            state_q <= S_DATA;
            idx_q   <= '0;
          end
        end

        S_DATA: begin
          if (dec_tick) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          if (wrap_tick) begin
            if (idx_q == IDX_LAST) begin
              state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              stop_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (dec_tick) perr_q <= ((^shift_q) ^ vote) != (PARITY_ODD != 0);
          if (wrap_tick) begin
            state_q <= S_STOP;
            stop_q  <= 1'b0;
          end
        end

        S_STOP: begin
          if (dec_tick) begin
            if (!vote) ferr_q <= 1'b1;
            // No wait for the end of the stop bit: a line still low here is
            // handled by the arm rule in IDLE.
            if (last_stop) state_q <= S_IDLE;
          end else if (wrap_tick) begin
            stop_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          ovr_q;

  logic full, pop, wr_en;

  assign full  = (count_q == CNT_FULL);
  assign pop   = o_rx_valid && i_rx_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= push_entry;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ovr_q <= push && full && !pop;
    end
  end

  assign o_rx_valid                              = (count_q != '0);
  assign {o_parity_err, o_frame_err, o_rx_data}  = mem_q[rd_q];
  assign o_overrun                               = ovr_q;
  assign o_fifo_count                            = count_q;
  assign o_busy                                  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param. Three instances cover different formats:
//   0: 8N1, OVERSAMPLE=16   1: 8E1, OVERSAMPLE=32   2: 5 data, 2 stop, OVERSAMPLE=8
// Each entry is handled as {parity_err, frame_err, data[7:0]}.

module tb_uart_rx_param;

  localparam int NB   [3] = '{8, 8, 5};
  localparam int PEN  [3] = '{0, 1, 0};
  localparam int PODD [3] = '{0, 0, 0};
  localparam int NS   [3] = '{1, 1, 2};
  localparam int OS   [3] = '{16, 32, 8};
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic tick = 1'b0;
  logic [2:0] rst_b = 3'b000;
  logic [2:0] rxd   = 3'b111;
  logic [2:0] rdy   = 3'b111;

  logic [2:0] valid, perr, ferr, ovr, busy;
  logic [7:0] rdata_a, rdata_p;
  logic [4:0] rdata_f;
  logic [2:0] cnt_a, cnt_p, cnt_f;

  int checks = 0;
  int failures = 0;

  logic [9:0] exp_q  [3][$];
  logic [9:0] rx_log [3][$];
  int exp_ovr  [3];
  int ovr_seen [3];
  bit busy_seen[3];

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  uart_rx_param u_a (
    .clk(clk), .reset(rst_b[0]), .i_clk_rx(tick), .i_rxd(rxd[0]), .i_rx_ready(rdy[0]),
    .o_rx_valid(valid[0]), .o_rx_data(rdata_a), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
    .o_overrun(ovr[0]), .o_fifo_count(cnt_a), .o_busy(busy[0])
  );

  uart_rx_param #(.OVERSAMPLE(32), .PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clk(clk), .reset(rst_b[1]), .i_clk_rx(tick), .i_rxd(rxd[1]), .i_rx_ready(rdy[1]),
    .o_rx_valid(valid[1]), .o_rx_data(rdata_p), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
    .o_overrun(ovr[1]), .o_fifo_count(cnt_p), .o_busy(busy[1])
  );

  uart_rx_param #(.DATA_BITS(5), .STOP_BITS(2), .OVERSAMPLE(8)) u_f (
    .clk(clk), .reset(rst_b[2]), .i_clk_rx(tick), .i_rxd(rxd[2]), .i_rx_ready(rdy[2]),
    .o_rx_valid(valid[2]), .o_rx_data(rdata_f), .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
    .o_overrun(ovr[2]), .o_fifo_count(cnt_f), .o_busy(busy[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int s, input logic v);
    rxd[s] = v;
    repeat (OS[s] * TICK_DIV) @(posedge clk);
    #1;
  endtask

  // Model: the expected entry follows from the character format rules. A frame
  // started while the consumer is stalled and DEPTH entries are already owed
  // can only be dropped with an overrun.
  task automatic send_char(input int s, input logic [7:0] d, input logic pbit,
                           input logic [1:0] stops);
    logic [7:0] dm;
    logic pe, fe;
    dm = d & 8'((1 << NB[s]) - 1);
    pe = (PEN[s] != 0) && (((^dm) ^ pbit) != (PODD[s] != 0));
    fe = !stops[0] || (NS[s] == 2 && !stops[1]);
    if (!rdy[s] && exp_q[s].size() == DEPTH) exp_ovr[s]++;
    else exp_q[s].push_back({pe, fe, dm});
    drive_bit(s, 1'b0);
    for (int i = 0; i < NB[s]; i++) drive_bit(s, d[i]);
    if (PEN[s] != 0) drive_bit(s, pbit);
    for (int i = 0; i < NS[s]; i++) drive_bit(s, stops[i]);
    drive_bit(s, 1'b1);
    drive_bit(s, 1'b1);
  endtask

  // Per-cycle compare against the model queues
  always @(negedge clk) begin : cmp
    logic [9:0] act;
    int c;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0:       begin act = {perr[0], ferr[0], rdata_a};         c = int'(cnt_a); end
        1:       begin act = {perr[1], ferr[1], rdata_p};         c = int'(cnt_p); end
        default: begin act = {perr[2], ferr[2], 3'b000, rdata_f}; c = int'(cnt_f); end
      endcase
      if (rst_b[s]) begin
        chk($sformatf("count_vs_valid[%0d]", s), int'(c != 0), int'(valid[s]));
        chk($sformatf("count_le_depth[%0d]", s), int'(c <= DEPTH), 1);
        if (busy[s]) busy_seen[s] = 1'b1;
        if (ovr[s]) ovr_seen[s]++;
        if (valid[s]) begin
          if (exp_q[s].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_char[%0d] actual=%h required=none", s, act);
          end else begin
            chk($sformatf("head[%0d]", s), int'(act), int'(exp_q[s][0]));
          end
          if (rdy[s]) begin
            rx_log[s].push_back(act);
            if (exp_q[s].size() != 0) void'(exp_q[s].pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int s = 0; s < 3; s++) begin
      exp_ovr[s]   = 0;
      ovr_seen[s]  = 0;
      busy_seen[s] = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1 rst_b = 3'b111;

    chk("rst_valid",  int'(valid[0]), 0);
    chk("rst_data",   int'(rdata_a), 0);
    chk("rst_perr",   int'(perr[0]), 0);
    chk("rst_ferr",   int'(ferr[0]), 0);
    chk("rst_ovr",    int'(ovr[0]), 0);
    chk("rst_count",  int'(cnt_a), 0);
    chk("rst_busy",   int'(busy[0]), 0);
    repeat (10) @(posedge clk);
    #1;

    // 8N1 basic character
    send_char(0, 8'hA5, 1'b0, 2'b11);
    chk("a5_n",    rx_log[0].size(), 1);
    chk("a5_data", int'(rx_log[0][0]), 10'h0A5);

    // Low stop bit, then a clean frame
    send_char(0, 8'h3C, 1'b0, 2'b00);
    send_char(0, 8'h55, 1'b0, 2'b11);
    chk("ferr_n",    rx_log[0].size(), 3);
    chk("ferr_data", int'(rx_log[0][1]), 10'h13C);
    chk("after_ferr_data", int'(rx_log[0][2]), 10'h055);

    // Four-tick glitch: false start, nothing pushed
    busy_seen[0] = 1'b0;
    rxd[0] = 1'b0;
    repeat (4 * TICK_DIV) @(posedge clk);
    #1 rxd[0] = 1'b1;
    repeat (3 * OS[0] * TICK_DIV) @(posedge clk);
    #1;
    chk("glitch_busy_seen", int'(busy_seen[0]), 1);
    chk("glitch_busy_end",  int'(busy[0]), 0);
    chk("glitch_no_push",   rx_log[0].size(), 3);
    chk("glitch_count",     int'(cnt_a), 0);

    // Break: exactly one zero character with a framing error
    exp_q[0].push_back(10'h100);
    rxd[0] = 1'b0;
    repeat (12 * OS[0] * TICK_DIV) @(posedge clk);
    #1 rxd[0] = 1'b1;
    repeat (3 * OS[0] * TICK_DIV) @(posedge clk);
    #1;
    chk("break_n",    rx_log[0].size(), 4);
    chk("break_data", int'(rx_log[0][3]), 10'h100);

    // Overrun with the consumer stalled
    rdy[0] = 1'b0;
    for (int i = 1; i <= 5; i++) send_char(0, 8'(i), 1'b0, 2'b11);
    chk("ovr_count", int'(cnt_a), 4);
    chk("ovr_pulses", ovr_seen[0], 1);
    rdy[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_count", int'(cnt_a), 0);
    chk("drain_n", rx_log[0].size(), 8);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain_%0d", i), int'(rx_log[0][4 + i]), i + 1);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct
    send_char(1, 8'h07, 1'b0, 2'b11);
    send_char(1, 8'h07, 1'b1, 2'b11);
    chk("par_n",   rx_log[1].size(), 2);
    chk("par_bad", int'(rx_log[1][0]), 10'h207);
    chk("par_ok",  int'(rx_log[1][1]), 10'h007);

    // Reset in DATA bit 2 of 0x1F discards the partial character
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b1);
    rxd[2] = 1'b1;
    repeat (OS[2] * TICK_DIV / 2) @(posedge clk);
    #1;
    chk("midframe_busy", int'(busy[2]), 1);
    rst_b[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("in_reset_busy",  int'(busy[2]), 0);
    chk("in_reset_valid", int'(valid[2]), 0);
    rst_b[2] = 1'b1;
    repeat (2 * OS[2] * TICK_DIV) @(posedge clk);
    #1;
    send_char(2, 8'h0A, 1'b0, 2'b11);
    chk("f5_n",    rx_log[2].size(), 1);
    chk("f5_data", int'(rx_log[2][0]), 10'h00A);

    for (int s = 0; s < 3; s++) begin
      chk($sformatf("model_drained[%0d]", s), exp_q[s].size(), 0);
      chk($sformatf("overrun_total[%0d]", s), ovr_seen[s], exp_ovr[s]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
